// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the register-mapped ALU: queues {a,b,op} commands, replays
// each as three cs/addr/write register writes, then captures and returns the result.
module alu_cmd_sequencer #(
  parameter int DW      = 3,
  parameter int RW      = 4,
  parameter int RES_LAT = 1,
  parameter int DEPTH   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic [1:0]    cmd_op,
  output logic          cs,
  output logic          write,
  output logic [1:0]    addr,
  output logic [DW-1:0] data_a,
  output logic [DW-1:0] data_b,
  output logic [1:0]    compute,
  input  logic [RW-1:0] alu_result,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [RW-1:0] res_data,
  output logic          busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;
  localparam int EW = 2 * DW + 2;

  typedef enum logic [3:0] {
    IDLE, WA_SET, WA_STB, WA_GAP, WB_SET, WB_STB, WB_GAP,
    OP_SET, OP_STB, OP_GAP, WAIT, DONE
  } state_t;

  state_t        state;
  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic [CW-1:0] cnt;
  logic          empty, full, push, pop;
  logic [EW-1:0] head;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign cmd_ready = en & ~full & ~reset;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == IDLE) & en & ~empty;
  assign head      = mem[rptr[AW-1:0]];
  assign busy      = (state != IDLE) | ~empty;

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {cmd_a, cmd_b, cmd_op};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // The DONE handshake is honoured even with en low so a stalled consumer never deadlocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cs        <= 1'b0;
      write     <= 1'b0;
      addr      <= 2'b00;
      data_a    <= '0;
      data_b    <= '0;
      compute   <= 2'b00;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (state == DONE) begin
      if (res_ready) begin
        res_valid <= 1'b0;
        state     <= IDLE;
      end
    end else if (en) begin
      case (state)
        IDLE: begin
          if (!empty) begin
            {data_a, data_b, compute} <= head;
            state <= WA_SET;
            cs    <= 1'b1;
            write <= 1'b0;
            addr  <= 2'b00;
          end
        end
        WA_SET: begin
          state <= WA_STB;
          write <= 1'b1;
        end
        WA_STB: begin
          state <= WA_GAP;
          cs    <= 1'b0;
          write <= 1'b0;
        end
        WA_GAP: begin
          state <= WB_SET;
          cs    <= 1'b1;
          addr  <= 2'b01;
        end
        WB_SET: begin
          state <= WB_STB;
          write <= 1'b1;
        end
        WB_STB: begin
          state <= WB_GAP;
          cs    <= 1'b0;
          write <= 1'b0;
        end
        WB_GAP: begin
          state <= OP_SET;
          cs    <= 1'b1;
          addr  <= 2'b10;
        end
        OP_SET: begin
          state <= OP_STB;
          write <= 1'b1;
        end
        OP_STB: begin
          state <= OP_GAP;
          cs    <= 1'b0;
          write <= 1'b0;
        end
        OP_GAP: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (cnt == CW'(RES_LAT - 1)) begin
            res_data  <= alu_result;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer driving a small register-mapped ALU stub.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset, en, cmd_valid, cmd_ready;
  logic [2:0] cmd_a, cmd_b;
  logic [1:0] cmd_op;
  logic       cs, write;
  logic [1:0] addr;
  logic [2:0] data_a, data_b;
  logic [1:0] compute;
  logic [3:0] alu_result;
  logic       res_valid, res_ready;
  logic [3:0] res_data;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] ra  = '0;
  logic [2:0] rb  = '0;
  logic [1:0] rop = '0;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk(clk), .reset(reset), .en(en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .cs(cs), .write(write), .addr(addr),
    .data_a(data_a), .data_b(data_b), .compute(compute),
    .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  // ALU stub: registers written on cs&write, op 00 is a+b
  always @(posedge clk) begin
    if (cs && write) begin
      case (addr)
        2'b00:   ra  <= data_a;
        2'b01:   rb  <= data_b;
        2'b10:   rop <= compute;
        default: ;
      endcase
    end
  end

  always_comb alu_result = (rop == 2'b00) ? ({1'b0, ra} + {1'b0, rb}) : 4'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] a, input logic [2:0] b);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = 2'b00;
    #1;
    check("send_ready", cmd_ready, 1);
  endtask

  task automatic wait_res(input int max);
    int n = 0;
    while (!res_valid && n < max) begin
      tick();
      n++;
    end
    check("wait_res", res_valid, 1);
  endtask

  task automatic bus_seq(input logic [2:0] ea, input logic [2:0] eb);
    for (int i = 0; i < 9; i++) begin
      check("seq_cs",    cs,    (i % 3 != 2) ? 1 : 0);
      check("seq_write", write, (i % 3 == 1) ? 1 : 0);
      check("seq_addr",  addr,  i / 3);
      check("seq_da",    data_a, ea);
      check("seq_db",    data_b, eb);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_res [3];
    int act;
    exp_res[0] = 4'hC; exp_res[1] = 4'h5; exp_res[2] = 4'hE;

    reset = 1'b1; en = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    res_ready = 1'b0;
    tick(); tick();
    check("rst_cs", cs, 0);
    check("rst_write", write, 0);
    check("rst_addr", addr, 0);
    check("rst_data_a", data_a, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // single command, exact latency
    res_ready = 1'b1;
    send(3'd5, 3'd7);
    tick();
    cmd_valid = 1'b0;
    check("t1_idle_cs", cs, 0);
    check("t1_busy", busy, 1);
    tick();
    bus_seq(3'd5, 3'd7);
    check("t1_wait_valid", res_valid, 0);
    tick();
    check("t1_res_valid", res_valid, 1);
    check("t1_res_data", res_data, 4'hC);
    tick();
    check("t1_valid_drop", res_valid, 0);
    check("t1_busy_end", busy, 0);

    // three back-to-back commands
    send(3'd5, 3'd7);
    tick();
    send(3'd3, 3'd2);
    tick();
    send(3'd7, 3'd7);
    tick();
    cmd_valid = 1'b0;
    #1;
    check("t2_full_ready", cmd_ready, 0);
    for (int k = 0; k < 3; k++) begin
      wait_res(40);
      check("t2_res_data", res_data, exp_res[k]);
      tick();
    end
    check("t2_valid_drop", res_valid, 0);
    check("t2_busy_end", busy, 0);

    // result backpressure with a second command queued
    res_ready = 1'b0;
    send(3'd1, 3'd2);
    tick();
    cmd_valid = 1'b0;
    wait_res(40);
    check("t3_res_data", res_data, 4'h3);
    send(3'd2, 3'd2);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", res_valid, 1);
      check("t3_hold_data", res_data, 4'h3);
      check("t3_no_cs", cs, 0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    check("t3_valid_drop", res_valid, 0);
    wait_res(40);
    check("t3_res2_data", res_data, 4'h4);
    tick();
    check("t3_valid_drop2", res_valid, 0);

    // enable stall at WB_STB
    send(3'd6, 3'd1);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("t4_wa_set_cs", cs, 1);
    check("t4_wa_set_addr", addr, 0);
    tick(); tick(); tick(); tick();
    en = 1'b0;
    #1;
    check("t4_stall_ready", cmd_ready, 0);
    for (int i = 0; i < 4; i++) begin
      check("t4_stall_cs", cs, 1);
      check("t4_stall_write", write, 1);
      check("t4_stall_addr", addr, 1);
      tick();
    end
    en = 1'b1;
    check("t4_last_stb_write", write, 1);
    tick();
    check("t4_gap_cs", cs, 0);
    check("t4_gap_write", write, 0);
    check("t4_gap_addr", addr, 1);
    wait_res(40);
    check("t4_res_data", res_data, 4'h7);
    tick();

    // reset during OP_SET with one command queued
    send(3'd1, 3'd1);
    tick();
    send(3'd2, 3'd3);
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick();
    check("t5_op_set_cs", cs, 1);
    check("t5_op_set_write", write, 0);
    check("t5_op_set_addr", addr, 2);
    reset = 1'b1;
    tick();
    check("t5_cs", cs, 0);
    check("t5_write", write, 0);
    check("t5_res_valid", res_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_rst_ready", cmd_ready, 0);
    reset = 1'b0;
    #1;
    check("t5_ready_after", cmd_ready, 1);
    act = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cs || res_valid || busy) act++;
    end
    check("t5_no_activity", act, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
